// File: rtl/probe_io_core.sv
// probe_io_core: bus-mapped probe block. Sits inline on a registered
// address/data bus, answers reads to its own window, and moves input and
// output probe values through buffers on a software-generated strobe.
module probe_io_core #(
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned N_IN      = 4,
   parameter int unsigned N_OUT     = 5,
   parameter int unsigned W         = 1,
   parameter logic [31:0] OUT_INIT  = 32'd0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [15:0]        addr_i,
   input  logic [15:0]        data_i,
   input  logic               rw_i,
   input  logic               valid_i,
   output logic [15:0]        addr_o,
   output logic [15:0]        data_o,
   output logic               rw_o,
   output logic               valid_o,
   input  logic [N_IN*W-1:0]  in_probes,
   output logic [N_OUT*W-1:0] out_probes
);

   localparam int unsigned FOOT   = 2 + 2*N_IN + 2*N_OUT;
   localparam int unsigned OB     = 2 + 2*N_IN;
   localparam logic [W-1:0] INIT_W = OUT_INIT[W-1:0];

   logic                       strobe, strobe_q, rise;
   logic [15:0]                cnt;
   logic [N_IN-1:0][W-1:0]     in_buf;
   logic [N_OUT-1:0][W-1:0]    out_buf;
   logic [31:0]                ob_ext [N_OUT];
   logic [16:0]                off;
   logic                       owned, rd_en, wr_en;
   logic [15:0]                rd_word;

   // Offset into our window; bit 16 is the borrow, set when addr_i < BASE_ADDR,
   // so no address ever wraps into the window.
   assign off   = {1'b0, addr_i} - 17'(BASE_ADDR);
   assign owned = ~off[16] && (off < 17'(FOOT));
   assign rd_en = valid_i & ~rw_i & owned;
   assign wr_en = valid_i &  rw_i & owned;
   assign rise  = strobe & ~strobe_q;

   function automatic logic [15:0] word_sel(input logic [W-1:0] v, input logic hi);
      logic [31:0] x;
      x = 32'(v);
      return hi ? x[31:16] : x[15:0];
   endfunction

   // Read mux plus zero-extended copies of the output buffers for word merges.
   always_comb begin
      rd_word = '0;
      if (off == 17'd0) rd_word = {15'd0, strobe};
      if (off == 17'd1) rd_word = cnt;
      for (int i = 0; i < int'(N_IN); i++) begin
         if (off == 17'(2 + 2*i)) rd_word = word_sel(in_buf[i], 1'b0);
         if (off == 17'(3 + 2*i)) rd_word = word_sel(in_buf[i], 1'b1);
      end
      for (int j = 0; j < int'(N_OUT); j++) begin
         ob_ext[j] = 32'(out_buf[j]);
         if (off == 17'(OB + 2*j))     rd_word = ob_ext[j][15:0];
         if (off == 17'(OB + 2*j + 1)) rd_word = ob_ext[j][31:16];
      end
   end

   // One-cycle bus pipeline; owned reads substitute the register contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_o  <= '0;
         data_o  <= '0;
         rw_o    <= 1'b0;
         valid_o <= 1'b0;
      end else begin
         addr_o  <= addr_i;
         data_o  <= rd_en ? rd_word : data_i;
         rw_o    <= rw_i;
         valid_o <= valid_i;
      end
   end

   // Strobe register, its delayed copy for edge detection, and the rise counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         strobe   <= 1'b0;
         strobe_q <= 1'b0;
         cnt      <= '0;
      end else begin
         strobe_q <= strobe;
         if (rise) cnt <= cnt + 16'd1;
         if (wr_en && off == 17'd0) strobe <= data_i[0];
      end
   end

   // Input buffers snapshot all probes together on a strobe rise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) in_buf <= '0;
      else if (rise) in_buf <= in_probes;
   end

   // Output buffers take bus writes; bits above W are dropped by the cast.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < int'(N_OUT); j++) out_buf[j] <= INIT_W;
      end else if (wr_en) begin
         for (int j = 0; j < int'(N_OUT); j++) begin
            if (off == 17'(OB + 2*j))     out_buf[j] <= W'({ob_ext[j][31:16], data_i});
            if (off == 17'(OB + 2*j + 1)) out_buf[j] <= W'({data_i, ob_ext[j][15:0]});
         end
      end
   end

   // Output probes load from the buffers only on a rise; a same-edge buffer
   // write is not seen here because out_buf is sampled pre-edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) out_probes <= {N_OUT{INIT_W}};
      else if (rise) out_probes <= out_buf;
   end

endmodule
